// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, BTB entry type and counter training helper for the fetch stage
package fetch_pkg;

    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    // Tag is held zero-extended to 30 bits so the type does not depend on the table size
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step: up on taken, down on not taken
    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SN) ? CTR_SN : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped branch target buffer with one comb read port and one trained write port
module btb_table
    import fetch_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Lookup_PC,
    output logic        Lookup_hit,
    output logic [1:0]  Lookup_ctr,
    output logic [31:0] Lookup_target,
    input  logic        Update_valid,
    input  logic [31:0] Update_PC,
    input  logic        Update_taken,
    input  logic [31:0] Update_target,
    input  logic [1:0]  Update_counter
);

    btb_entry_t table_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [29:0]      rd_tag;
    btb_entry_t       rd_entry;
    logic [IDX_W-1:0] wr_idx;
    logic [29:0]      wr_tag;
    logic             wr_hit;

    // Byte-offset bits of the addresses never take part in indexing
    logic unused_low_bits;
    assign unused_low_bits = ^{Lookup_PC[1:0], Update_PC[1:0], Update_target[1:0]};

    // Read port: pre-update contents, so a same-cycle write is seen only next cycle
    always_comb begin
        rd_idx        = Lookup_PC[IDX_W+1:2];
        rd_tag        = Lookup_PC[31:2] >> IDX_W;
        rd_entry      = table_q[rd_idx];
        Lookup_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
        Lookup_ctr    = rd_entry.ctr;
        Lookup_target = {rd_entry.target, 2'b00};
    end

    // Write-side index/tag match for the resolved branch
    always_comb begin
        wr_idx = Update_PC[IDX_W+1:2];
        wr_tag = Update_PC[31:2] >> IDX_W;
        wr_hit = table_q[wr_idx].valid && (table_q[wr_idx].tag == wr_tag);
    end

    // Training: refresh a hit entry, allocate on a taken miss, ignore a not-taken miss
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (Update_valid) begin
            if (wr_hit) begin
                table_q[wr_idx].ctr <= ctr_train(Update_counter, Update_taken);
                if (Update_taken) begin
                    table_q[wr_idx].target <= Update_target[31:2];
                end
            end else if (Update_taken) begin
                table_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag,
                                     target: Update_target[31:2], ctr: CTR_WT};
            end
        end
    end

endmodule

// File: rtl/fetch_predict.sv
// rtl/fetch_predict.sv - instruction fetch stage: PC register, next-PC selection and BTB prediction
module fetch_predict
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Redirect_valid,
    input  logic [31:0] Redirect_addr,
    output logic [31:0] Instr_address_2IM,
    input  logic [31:0] Instr1_fIM,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4,
    output logic        Branch_prediction_OUT,
    output logic [31:0] Branch_prediction_addr_OUT,
    output logic [1:0]  Branch_predictions_OUT,
    input  logic        Update_valid,
    input  logic [31:0] Update_PC,
    input  logic        Update_taken,
    input  logic [31:0] Update_target,
    input  logic [1:0]  Update_counter
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        btb_hit;
    logic [1:0]  btb_ctr;
    logic [31:0] btb_target;
    logic        pred_taken;

    btb_table #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_btb (
        .CLK            (CLK),
        .RESET          (RESET),
        .Lookup_PC      (pc_q),
        .Lookup_hit     (btb_hit),
        .Lookup_ctr     (btb_ctr),
        .Lookup_target  (btb_target),
        .Update_valid   (Update_valid),
        .Update_PC      (Update_PC),
        .Update_taken   (Update_taken),
        .Update_target  (Update_target),
        .Update_counter (Update_counter)
    );

    // Prediction is purely combinational from the current PC; a miss reads as weakly not-taken
    always_comb begin
        pc_plus4                   = pc_q + 32'd4;
        pred_taken                 = btb_hit && btb_ctr[1];
        Instr_address_2IM          = pc_q;
        Instr_PC_OUT               = pc_q;
        Instr_PC_Plus4             = pc_plus4;
        Instr1_OUT                 = Instr1_fIM;
        Branch_predictions_OUT     = btb_hit ? btb_ctr : CTR_WN;
        Branch_prediction_OUT      = pred_taken;
        Branch_prediction_addr_OUT = pred_taken ? btb_target : pc_plus4;
    end

    // Next PC: redirect beats stall, stall beats the predicted path
    always_comb begin
        pc_d = Branch_prediction_addr_OUT;
        if (Redirect_valid) begin
            pc_d = Redirect_addr;
        end else if (STALL) begin
            pc_d = pc_q;
        end
    end

    // PC register; reset wins over redirect and stall
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// tb/tb_fetch_predict.sv - randomized self-checking bench for fetch_predict against a BTB reference model
module tb_fetch_predict;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        Redirect_valid = 1'b0;
    logic [31:0] Redirect_addr = '0;
    logic [31:0] Instr_address_2IM;
    logic [31:0] Instr1_fIM = '0;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4;
    logic        Branch_prediction_OUT;
    logic [31:0] Branch_prediction_addr_OUT;
    logic [1:0]  Branch_predictions_OUT;
    logic        Update_valid = 1'b0;
    logic [31:0] Update_PC = '0;
    logic        Update_taken = 1'b0;
    logic [31:0] Update_target = '0;
    logic [1:0]  Update_counter = '0;

    fetch_predict dut (
        .CLK                        (CLK),
        .RESET                      (RESET),
        .STALL                      (STALL),
        .Redirect_valid             (Redirect_valid),
        .Redirect_addr              (Redirect_addr),
        .Instr_address_2IM          (Instr_address_2IM),
        .Instr1_fIM                 (Instr1_fIM),
        .Instr1_OUT                 (Instr1_OUT),
        .Instr_PC_OUT               (Instr_PC_OUT),
        .Instr_PC_Plus4             (Instr_PC_Plus4),
        .Branch_prediction_OUT      (Branch_prediction_OUT),
        .Branch_prediction_addr_OUT (Branch_prediction_addr_OUT),
        .Branch_predictions_OUT     (Branch_predictions_OUT),
        .Update_valid               (Update_valid),
        .Update_PC                  (Update_PC),
        .Update_taken               (Update_taken),
        .Update_target              (Update_target),
        .Update_counter             (Update_counter)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: 16 direct-mapped slots, tag = pc / 64, counters as plain ints
    logic [31:0] m_pc;
    bit          m_init = 1'b0;
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) & 32'hF);
    endfunction

    task automatic step(input logic rst, input logic stall, input logic rv, input logic [31:0] ra,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic [1:0] uctr);
        int          i;
        bit          hit;
        int          pctr;
        bit          ptaken;
        logic [31:0] paddr;
        int          c;
        @(negedge CLK);
        RESET = rst; STALL = stall; Redirect_valid = rv; Redirect_addr = ra;
        Update_valid = uv; Update_PC = upc; Update_taken = ut;
        Update_target = utgt; Update_counter = uctr;
        Instr1_fIM = $urandom;
        #1;
        hit = 1'b0; pctr = 1; ptaken = 1'b0; paddr = m_pc + 32'd4;
        if (m_init) begin
            i      = slot(m_pc);
            hit    = m_valid[i] && (m_tag[i] == (m_pc >> 6));
            pctr   = hit ? m_ctr[i] : 1;
            ptaken = (pctr >= 2);
            paddr  = ptaken ? m_target[i] : m_pc + 32'd4;
            chk("imem_addr", Instr_address_2IM, m_pc);
            chk("pc_out", Instr_PC_OUT, m_pc);
            chk("pc_plus4", Instr_PC_Plus4, m_pc + 32'd4);
            chk("instr", Instr1_OUT, Instr1_fIM);
            chk("pred", {31'd0, Branch_prediction_OUT}, {31'd0, ptaken});
            chk("pred_addr", Branch_prediction_addr_OUT, paddr);
            chk("pred_ctr", {30'd0, Branch_predictions_OUT}, 32'(pctr));
        end
        @(posedge CLK);
        if (!rst) begin
            m_pc = 32'h0000_0000;
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_pc = rv ? ra : (stall ? m_pc : paddr);
            if (uv) begin
                i = slot(upc);
                if (m_valid[i] && (m_tag[i] == (upc >> 6))) begin
                    c = ut ? int'(uctr) + 1 : int'(uctr) - 1;
                    m_ctr[i] = (c > 3) ? 3 : ((c < 0) ? 0 : c);
                    if (ut) m_target[i] = utgt & ~32'h3;
                end else if (ut) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = upc >> 6;
                    m_target[i] = utgt & ~32'h3;
                    m_ctr[i]    = 2;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic stall);
        step(1'b1, stall, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
    endtask

    task automatic go(input logic [31:0] a);
        step(1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic [1:0] c);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, pc, t, tgt, c);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] upc;

        // Reset for two cycles, including an update and redirect that must be ignored
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h10, 1'b1, 32'h80, 2'b01);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
        chk("rst_pc", Instr_PC_OUT, 32'h0);
        chk("rst_plus4", Instr_PC_Plus4, 32'h4);
        chk("rst_pred", {31'd0, Branch_prediction_OUT}, 32'h0);
        chk("rst_ctr", {30'd0, Branch_predictions_OUT}, 32'h1);
        idle(1'b0); chk("seq_4", Instr_address_2IM, 32'h4);
        idle(1'b0); chk("seq_8", Instr_address_2IM, 32'h8);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1); chk("stall_hold", Instr_address_2IM, 32'h8);
        end
        idle(1'b0); chk("seq_c", Instr_address_2IM, 32'hC);

        // Redirect beats stall
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
        chk("redir", Instr_PC_OUT, 32'h100);

        // Allocate 0x10 -> 0x40 while redirecting to 0x10
        step(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h40, 2'b01);
        chk("alloc_pred", {31'd0, Branch_prediction_OUT}, 32'h1);
        chk("alloc_addr", Branch_prediction_addr_OUT, 32'h40);
        chk("alloc_ctr", {30'd0, Branch_predictions_OUT}, 32'h2);
        idle(1'b0); chk("follow_pred", Instr_PC_OUT, 32'h40);

        // Saturation at both ends
        train(32'h10, 1'b1, 32'h40, 2'b11);
        train(32'h10, 1'b1, 32'h40, 2'b11);
        go(32'h10); chk("sat_hi", {30'd0, Branch_predictions_OUT}, 32'h3);
        train(32'h10, 1'b0, 32'h0, 2'b00);
        train(32'h10, 1'b0, 32'h0, 2'b00);
        go(32'h10);
        chk("sat_lo", {30'd0, Branch_predictions_OUT}, 32'h0);
        chk("sat_lo_pred", {31'd0, Branch_prediction_OUT}, 32'h0);

        // Alias at same index, different tag
        train(32'h10, 1'b1, 32'h40, 2'b01);
        go(32'h50); chk("alias_miss", {30'd0, Branch_predictions_OUT}, 32'h1);
        train(32'h50, 1'b0, 32'h0, 2'b01);
        go(32'h10);
        chk("alias_keep_ctr", {30'd0, Branch_predictions_OUT}, 32'h2);
        chk("alias_keep_addr", Branch_prediction_addr_OUT, 32'h40);

        // Wrap of PC+4
        go(32'hFFFF_FFFC); chk("wrap", Instr_PC_Plus4, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ra  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255));
            upc = ($urandom_range(0, 3) == 0 ? 32'h0000_1000 : 32'h0) | 32'($urandom_range(0, 127));
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, ra,
                 $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0,
                 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
